// File: rtl/load_store_unit_pkg.sv
// load_store_unit_pkg: funct3 access codes and the latched access descriptor
// shared by the load/store unit and its alignment datapath.
package load_store_unit_pkg;
    localparam logic [2:0] FNC_LB  = 3'b000;
    localparam logic [2:0] FNC_LH  = 3'b001;
    localparam logic [2:0] FNC_LW  = 3'b010;
    localparam logic [2:0] FNC_LBU = 3'b100;
    localparam logic [2:0] FNC_LHU = 3'b101;
    localparam logic [2:0] FNC_SB  = 3'b000;
    localparam logic [2:0] FNC_SH  = 3'b001;
    localparam logic [2:0] FNC_SW  = 3'b010;
    typedef struct packed {
        logic       is_store;
        logic [2:0] funct3;
        logic [1:0] off;
    } acc_t;
endpackage

// File: rtl/lsu_align.sv
// lsu_align: store lane shift and byte enables, load lane select with
// sign/zero extension, and the misalignment check.
module lsu_align
    import load_store_unit_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  off_i,
    input  logic [31:0] store_data_i,
    input  logic [31:0] rdata_i,
    output logic [31:0] wdata_o,
    output logic [3:0]  be_o,
    output logic [31:0] rdata_o,
    output logic        misaligned_o
);
    logic [1:0]  size;
    logic        sext;
    logic [31:0] lane;
    always_comb begin
        size         = funct3_i[1:0];
        sext         = !(funct3_i inside {FNC_LBU, FNC_LHU});
        lane         = rdata_i >> {off_i, 3'b000};
        wdata_o      = store_data_i << {off_i, 3'b000};
        be_o         = size == FNC_SB[1:0] ? 4'b0001 << off_i :
                       size == FNC_SH[1:0] ? 4'b0011 << off_i : 4'b1111;
        // aligned words always have off_i == 0, so lane is the raw word
        rdata_o      = size == FNC_LB[1:0] ? {{24{sext & lane[7]}}, lane[7:0]} :
                       size == FNC_LH[1:0] ? {{16{sext & lane[15]}}, lane[15:0]} : lane;
        misaligned_o = (size == FNC_LH[1:0] && off_i[0]) ||
                       (size == FNC_LW[1:0] && off_i != 2'b00);
    end
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: turns a memory-stage load/store into a req/gnt/rvalid
// transaction on the data-memory port, stalling the pipeline until done.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int AWIDTH = 32,
    parameter int DWIDTH = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [2:0]        funct3,
    input  logic [AWIDTH-1:0] addr,
    input  logic [DWIDTH-1:0] store_data,
    output logic              stall,
    output logic              load_valid,
    output logic [DWIDTH-1:0] load_data,
    output logic              misaligned,
    output logic              dmem_req,
    output logic [3:0]        dmem_we,
    output logic [AWIDTH-1:0] dmem_addr,
    output logic [DWIDTH-1:0] dmem_wdata,
    input  logic              dmem_gnt,
    input  logic              dmem_rvalid,
    input  logic [DWIDTH-1:0] dmem_rdata
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_e;

    state_e            state_q, state_d;
    acc_t              acc_q, acc_d;
    logic [AWIDTH-3:0] addr_q, addr_d;
    logic [3:0]        we_q, we_d;
    logic [DWIDTH-1:0] wdata_q, wdata_d, ldata_q, ldata_d;
    logic              idle, mis;
    logic [2:0]        fnc;
    logic [1:0]        off;
    logic [3:0]        be;
    logic [DWIDTH-1:0] sh_wdata, ext_rdata;

    // store shaping uses the live instruction, load extension the latched one
    assign idle = state_q == IDLE;
    assign fnc  = idle ? funct3 : acc_q.funct3;
    assign off  = idle ? addr[1:0] : acc_q.off;

    lsu_align u_align (
        .funct3_i    (fnc),
        .off_i       (off),
        .store_data_i(store_data),
        .rdata_i     (dmem_rdata),
        .wdata_o     (sh_wdata),
        .be_o        (be),
        .rdata_o     (ext_rdata),
        .misaligned_o(mis)
    );

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        addr_d     = addr_q;
        we_d       = we_q;
        wdata_d    = wdata_q;
        ldata_d    = ldata_q;
        stall      = 1'b0;
        misaligned = 1'b0;
        case (state_q)
            IDLE: if (mem_read || mem_write) begin
                misaligned = mis;
                stall      = !mis;
                if (!mis) begin
                    state_d = REQ;
                    acc_d   = acc_t'{mem_write, funct3, addr[1:0]};
                    addr_d  = addr[AWIDTH-1:2];
                    we_d    = mem_write ? be : 4'b0000;
                    wdata_d = mem_write ? sh_wdata : '0;
                end
            end
            REQ: begin
                stall = 1'b1;
                if (dmem_gnt) state_d = acc_q.is_store ? DONE : WAIT;
            end
            WAIT: begin
                stall = 1'b1;
                if (dmem_rvalid) begin
                    ldata_d = ext_rdata;
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            addr_q  <= '0;
            we_q    <= '0;
            wdata_q <= '0;
            ldata_q <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            ldata_q <= ldata_d;
        end
    end

    assign dmem_req   = state_q == REQ;
    assign dmem_we    = we_q;
    assign dmem_addr  = {addr_q, 2'b00};
    assign dmem_wdata = wdata_q;
    assign load_data  = ldata_q;
    assign load_valid = state_q == DONE && !acc_q.is_store;
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed load/store vectors; expected bus requests and
// load results go into queues checked by an independent monitor.
module tb_load_store_unit;
    logic        clk = 1'b0, rst = 1'b1;
    logic        mem_read = 1'b0, mem_write = 1'b0;
    logic [2:0]  funct3 = 3'b000;
    logic [31:0] addr = '0, store_data = '0;
    logic        stall, load_valid, misaligned, dmem_req;
    logic [31:0] load_data, dmem_addr, dmem_wdata;
    logic [3:0]  dmem_we;
    logic        dmem_gnt = 1'b0, dmem_rvalid = 1'b0;
    logic [31:0] dmem_rdata = '0;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  we;
        logic [31:0] wdata;
        logic        chk_wd;
    } req_t;

    req_t        exp_req[$];
    logic [31:0] exp_ld[$];
    int          exp_mis = 0;
    int          errors = 0, checks = 0;

    load_store_unit dut (
        .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
        .funct3(funct3), .addr(addr), .store_data(store_data), .stall(stall),
        .load_valid(load_valid), .load_data(load_data), .misaligned(misaligned),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid),
        .dmem_rdata(dmem_rdata)
    );

    always #5 clk = ~clk;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    function automatic void fail(string name);
        checks++;
        errors++;
        $display("FAIL %s", name);
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            if (dmem_req) begin
                if (exp_req.size() == 0) fail("unexpected_dmem_req");
                else begin
                    check("req_addr", dmem_addr, exp_req[0].addr);
                    check("req_we", {28'b0, dmem_we}, {28'b0, exp_req[0].we});
                    if (exp_req[0].chk_wd) check("req_wdata", dmem_wdata, exp_req[0].wdata);
                    if (dmem_gnt) void'(exp_req.pop_front());
                end
            end
            if (load_valid) begin
                if (exp_ld.size() == 0) fail("unexpected_load_valid");
                else check("load_data", load_data, exp_ld.pop_front());
            end
            if (misaligned) begin
                if (exp_mis == 0) fail("unexpected_misaligned");
                else begin
                    exp_mis--;
                    check("mis_no_req", {31'b0, dmem_req}, 32'd0);
                    check("mis_no_stall", {31'b0, stall}, 32'd0);
                end
            end
        end
    end

    task automatic access(input logic rd, input logic wr, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] sd, input logic [31:0] rdat,
                          input int gd, input int rvd, input logic [3:0] ewe,
                          input logic [31:0] ewd, input logic [31:0] eld, input int estall);
        int stalls = 0;
        bit done = 1'b0;
        exp_req.push_back('{addr: {a[31:2], 2'b00}, we: ewe, wdata: ewd, chk_wd: wr});
        if (!wr) exp_ld.push_back(eld);
        mem_read = rd; mem_write = wr; funct3 = f3; addr = a; store_data = sd; dmem_rdata = rdat;
        for (int c = 0; c < 40 && !done; c++) begin
            dmem_gnt    = (c == 1 + gd);
            dmem_rvalid = !wr && (c == 1 + gd + rvd);
            @(negedge clk);
            if (stall) stalls++;
            else done = 1'b1;
            @(posedge clk); #1;
        end
        mem_read = 1'b0; mem_write = 1'b0; dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
        if (!done) fail("access_timeout");
        check("stall_cycles", 32'(stalls), 32'(estall));
    endtask

    task automatic misal(input logic wr, input logic [2:0] f3, input logic [31:0] a);
        exp_mis++;
        mem_read = !wr; mem_write = wr; funct3 = f3; addr = a; store_data = 32'h55;
        @(negedge clk);
        check("mis_pulse", {31'b0, misaligned}, 32'd1);
        @(posedge clk); #1;
        mem_read = 1'b0; mem_write = 1'b0;
        @(negedge clk);
        check("mis_after_stall", {31'b0, stall}, 32'd0);
        check("mis_after_req", {31'b0, dmem_req}, 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_stall", {31'b0, stall}, 32'd0);
        check("rst_req", {31'b0, dmem_req}, 32'd0);
        check("rst_load_valid", {31'b0, load_valid}, 32'd0);
        check("rst_load_data", load_data, 32'd0);
        check("rst_addr", dmem_addr, 32'd0);
        @(posedge clk); #1;
        //     rd    wr    f3      addr          sdata         rdata         gd rv we       wdata         load          stall
        access(1'b0, 1'b1, 3'b010, 32'h0000_1004, 32'hDEAD_BEEF, 32'h0,        0, 1, 4'b1111, 32'hDEAD_BEEF, 32'h0,        2);
        access(1'b0, 1'b1, 3'b000, 32'h0000_2003, 32'h0000_00A5, 32'h0,        0, 1, 4'b1000, 32'hA500_0000, 32'h0,        2);
        access(1'b0, 1'b1, 3'b001, 32'h0000_3002, 32'hFFFF_1234, 32'h0,        1, 1, 4'b1100, 32'h1234_0000, 32'h0,        3);
        access(1'b1, 1'b1, 3'b000, 32'h0000_3001, 32'h0000_0077, 32'h0,        0, 1, 4'b0010, 32'h0000_7700, 32'h0,        2);
        access(1'b1, 1'b0, 3'b000, 32'h0000_4002, 32'h0,         32'h80F07F01, 0, 1, 4'b0000, 32'h0,         32'hFFFF_FFF0, 3);
        access(1'b1, 1'b0, 3'b100, 32'h0000_4003, 32'h0,         32'h80F07F01, 0, 1, 4'b0000, 32'h0,         32'h0000_0080, 3);
        access(1'b1, 1'b0, 3'b001, 32'h0000_4002, 32'h0,         32'h80F07F01, 0, 1, 4'b0000, 32'h0,         32'hFFFF_80F0, 3);
        access(1'b1, 1'b0, 3'b101, 32'h0000_4000, 32'h0,         32'h80F07F01, 0, 1, 4'b0000, 32'h0,         32'h0000_7F01, 3);
        access(1'b1, 1'b0, 3'b000, 32'h0000_4001, 32'h0,         32'h80F07F01, 0, 1, 4'b0000, 32'h0,         32'h0000_007F, 3);
        access(1'b1, 1'b0, 3'b010, 32'h0000_5000, 32'h0,         32'h13579BDF, 2, 2, 4'b0000, 32'h0,         32'h1357_9BDF, 6);
        misal(1'b0, 3'b001, 32'h0000_1001);
        misal(1'b0, 3'b010, 32'h0000_1002);
        misal(1'b1, 3'b010, 32'h0000_1001);
        // reset while waiting for read data; the late rvalid must be dropped
        exp_req.push_back('{addr: 32'h0000_6000, we: 4'b0000, wdata: 32'h0, chk_wd: 1'b0});
        mem_read = 1'b1; funct3 = 3'b010; addr = 32'h0000_6000;
        @(posedge clk); #1 dmem_gnt = 1'b1;
        @(posedge clk); #1 dmem_gnt = 1'b0; mem_read = 1'b0;
        @(negedge clk);
        check("wait_stall", {31'b0, stall}, 32'd1);
        #2 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        dmem_rvalid = 1'b1; dmem_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        check("post_rst_stall", {31'b0, stall}, 32'd0);
        @(posedge clk); #1 dmem_rvalid = 1'b0;
        @(negedge clk);
        check("post_rst_load_valid", {31'b0, load_valid}, 32'd0);
        check("post_rst_load_data", load_data, 32'd0);
        check("post_rst_req", {31'b0, dmem_req}, 32'd0);
        check("post_rst_we", {28'b0, dmem_we}, 32'd0);
        check("post_rst_addr", dmem_addr, 32'd0);
        check("post_rst_wdata", dmem_wdata, 32'd0);
        repeat (2) @(negedge clk);
        check("req_queue_empty", 32'(exp_req.size()), 32'd0);
        check("load_queue_empty", 32'(exp_ld.size()), 32'd0);
        check("mis_all_seen", 32'(exp_mis), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
